histogram_accumulator: RTL and testbench

- Builds a per-frame intensity histogram from a pixel stream and emits it as one flat word to the histogram derivative stage.
- Emits over a valid/ready handshake.
- Working bins and the output register are separate, so accumulation of frame N+1 overlaps delivery of frame N.
- Stalls the pixel stream only when a frame completes while the previous histogram is still unaccepted.

---
 rtl/histogram_accumulator_if.sv | 44 ++++
 rtl/histogram_accumulator.sv | 136 +++++++++++++
 tb/tb_histogram_accumulator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_accumulator_if.sv
// Pixel-stream and histogram-output signals for histogram_accumulator.
//   i_pixel, i_pixel_valid, i_frame_end : pixel beat from the source
//   o_pixel_ready                       : pixel beat ready back to the source
//   o_histogram_flat, o_frame_saturated : completed histogram to the consumer
//   o_valid / i_ready                   : histogram handshake
// The slave modport is the accumulator's view; master is the view of the
// source/consumer pair that drives it.
interface histogram_accumulator_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int BIN_WIDTH   = 16,
    parameter int NUM_BINS    = 2**PIXEL_WIDTH,
    parameter int HISTO_SIZE  = NUM_BINS*BIN_WIDTH-1
);
    logic [PIXEL_WIDTH-1:0] i_pixel;
    logic                   i_pixel_valid;
    logic                   i_frame_end;
    logic                   o_pixel_ready;
    logic [HISTO_SIZE:0]    o_histogram_flat;
    logic                   o_frame_saturated;
    logic                   o_valid;
    logic                   i_ready;

    modport slave (
        input  i_pixel,
        input  i_pixel_valid,
        input  i_frame_end,
        input  i_ready,
        output o_pixel_ready,
        output o_histogram_flat,
        output o_frame_saturated,
        output o_valid
    );

    modport master (
        output i_pixel,
        output i_pixel_valid,
        output i_frame_end,
        output i_ready,
        input  o_pixel_ready,
        input  o_histogram_flat,
        input  o_frame_saturated,
        input  o_valid
    );
endinterface

// File: rtl/histogram_accumulator.sv
// Per-frame intensity histogram builder.
// Counts accepted pixels into 2**PIXEL_WIDTH saturating bins and, at each
// frame end, moves the bins into a separate output register presented over a
// valid/ready handshake, so the next frame accumulates while the previous one
// is delivered. The pixel stream is stalled only when a frame ends while the
// previous histogram has not yet been taken.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous reset, active high
//   bus      : histogram_accumulator_if.slave (pixel input + histogram output)
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_ACCUMULATE | accepting pixels; frame end transfers if the slot is free
// S_HOLD       | frame complete but output slot busy; pixels stalled until
//              | the consumer takes the current histogram
module histogram_accumulator #(
    parameter int PIXEL_WIDTH = 8,
    parameter int BIN_WIDTH   = 16,
    parameter int NUM_BINS    = 2**PIXEL_WIDTH,
    parameter int HISTO_SIZE  = NUM_BINS*BIN_WIDTH-1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    histogram_accumulator_if.slave  bus
);
    localparam int BASE_W = $clog2(HISTO_SIZE+1);

    localparam logic [0:0] S_ACCUMULATE = 1'b0;
    localparam logic [0:0] S_HOLD       = 1'b1;

    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic                 pixel_ready_q;
    logic [HISTO_SIZE:0]  bins_q;
    logic [HISTO_SIZE:0]  bins_upd;
    logic [HISTO_SIZE:0]  hist_q;
    logic                 sat_flag_q;
    logic                 sat_out_q;
    logic                 valid_q;

    logic [BASE_W-1:0]    bin_base;
    logic [BIN_WIDTH-1:0] bin_sel;
    logic [BIN_WIDTH-1:0] bin_inc;
    logic                 bin_full;
    logic                 pix_accept;
    logic                 frame_done;
    logic                 slot_free;
    logic                 out_accept;
    logic                 do_transfer;
    logic                 sat_upd;

    assign pix_accept = bus.i_pixel_valid & pixel_ready_q;
    assign frame_done = pix_accept & bus.i_frame_end;
    assign slot_free  = !valid_q | bus.i_ready;
    assign out_accept = valid_q & bus.i_ready;

    // One bin is read, incremented and written back per accepted pixel; the
    // same updated vector feeds both the working bins and the output register
    // so the frame-end pixel lands in the frame it closes.
    assign bin_base = BASE_W'(bus.i_pixel) * BASE_W'(BIN_WIDTH);
    assign bin_sel  = bins_q[bin_base +: BIN_WIDTH];
    assign bin_full = &bin_sel;
    assign bin_inc  = bin_full ? bin_sel : bin_sel + BIN_WIDTH'(1);

    always_comb begin
        bins_upd = bins_q;
        if (pix_accept) begin
            bins_upd[bin_base +: BIN_WIDTH] = bin_inc;
        end
    end

    assign sat_upd = sat_flag_q | (pix_accept & bin_full);

    always_comb begin
        state_d     = state_q;
        do_transfer = 1'b0;
        case (state_q)
            S_ACCUMULATE: begin
                if (frame_done) begin
                    if (slot_free) begin
                        do_transfer = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // o_valid is necessarily high here, so i_ready alone means
                // the held histogram is being taken this cycle.
                if (bus.i_ready) begin
                    do_transfer = 1'b1;
                    state_d     = S_ACCUMULATE;
                end
            end
            default: begin
                state_d = S_ACCUMULATE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_ACCUMULATE;
            pixel_ready_q <= 1'b0;
            bins_q        <= '0;
            sat_flag_q    <= 1'b0;
            hist_q        <= '0;
            sat_out_q     <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered copy of "next state is S_ACCUMULATE": keeps ready
            // free of any input-to-output path and low during reset.
            pixel_ready_q <= (state_d == S_ACCUMULATE);
            if (do_transfer) begin
                hist_q     <= bins_upd;
                sat_out_q  <= sat_upd;
                valid_q    <= 1'b1;
                bins_q     <= '0;
                sat_flag_q <= 1'b0;
            end else begin
                bins_q     <= bins_upd;
                sat_flag_q <= sat_upd;
                if (out_accept) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_pixel_ready     = pixel_ready_q;
    assign bus.o_histogram_flat  = hist_q;
    assign bus.o_frame_saturated = sat_out_q;
    assign bus.o_valid           = valid_q;
endmodule

// File: tb/tb_histogram_accumulator.sv
// Testbench for histogram_accumulator: directed steps from the test plan plus
// a randomized phase, all compared against a cycle-level array model.
module tb_histogram_accumulator;
    localparam int PW   = 8;
    localparam int BW   = 16;
    localparam int NB   = 2**PW;
    localparam int HS   = NB*BW-1;
    localparam int MAXB = 2**BW-1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    histogram_accumulator_if #(.PIXEL_WIDTH(PW), .BIN_WIDTH(BW)) bus ();

    histogram_accumulator #(.PIXEL_WIDTH(PW), .BIN_WIDTH(BW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: working bins, presented histogram, flags.
    int mb[NB];
    int mout[NB];
    bit msat, mout_sat, mvalid, mready, mhold;

    task automatic model_edge();
        bit acc, sat_now, xfer;
        int p;
        if (rst) begin
            foreach (mb[k]) begin
                mb[k]   = 0;
                mout[k] = 0;
            end
            msat = 0; mout_sat = 0; mvalid = 0; mready = 0; mhold = 0;
        end else begin
            acc     = bus.i_pixel_valid && mready;
            p       = int'(bus.i_pixel);
            sat_now = 0;
            xfer    = 0;
            if (acc) begin
                if (mb[p] == MAXB) sat_now = 1;
                else mb[p] = mb[p] + 1;
            end
            if (mhold) begin
                if (bus.i_ready) begin
                    xfer  = 1;
                    mhold = 0;
                end
            end else if (acc && bus.i_frame_end) begin
                if (!mvalid || bus.i_ready) xfer = 1;
                else mhold = 1;
            end
            if (xfer) begin
                mout     = mb;
                mout_sat = msat | sat_now;
                foreach (mb[k]) mb[k] = 0;
                msat   = 0;
                mvalid = 1;
            end else begin
                msat = msat | sat_now;
                if (mvalid && bus.i_ready) mvalid = 0;
            end
            mready = !mhold;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_hist(input string tag);
        logic [HS:0] e;
        int d;
        for (int k = 0; k < NB; k++) e[k*BW +: BW] = mout[k][BW-1:0];
        n_checks++;
        assert (bus.o_histogram_flat === e) n_pass++;
        else begin
            d = 0;
            for (int k = 0; k < NB; k++) begin
                if (bus.o_histogram_flat[k*BW +: BW] !== e[k*BW +: BW]) begin
                    d = k;
                    break;
                end
            end
            $error("FAIL %s: bin %0d observed %0h expected %0h", tag, d,
                   bus.o_histogram_flat[d*BW +: BW], e[d*BW +: BW]);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(mvalid));
        chk({tag, ".pixel_ready"}, 32'(bus.o_pixel_ready), 32'(mready));
        chk_hist({tag, ".hist"});
        if (mvalid) chk({tag, ".sat"}, 32'(bus.o_frame_saturated), 32'(mout_sat));
    endtask

    task automatic beat(input int p, input bit fe);
        bus.i_pixel_valid = 1'b1;
        bus.i_pixel       = PW'(p);
        bus.i_frame_end   = fe;
        step();
    endtask

    task automatic idle();
        bus.i_pixel_valid = 1'b0;
        bus.i_frame_end   = 1'b0;
        step();
    endtask

    function automatic logic [31:0] obin(input int k);
        return 32'(bus.o_histogram_flat[k*BW +: BW]);
    endfunction

    int basic_px[10] = '{5, 5, 5, 5, 200, 200, 200, 200, 200, 0};

    initial begin
        rst = 1'b1;
        bus.i_pixel       = '0;
        bus.i_pixel_valid = 1'b0;
        bus.i_frame_end   = 1'b0;
        bus.i_ready       = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset.valid", 32'(bus.o_valid), 0);
            chk("reset.pixel_ready", 32'(bus.o_pixel_ready), 0);
            chk("reset.hist_zero", 32'(bus.o_histogram_flat != '0), 0);
        end
        rst = 1'b0;
        step();
        chk("post_reset.pixel_ready", 32'(bus.o_pixel_ready), 1);
        check_model("post_reset");

        // Basic frame
        bus.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            beat(basic_px[i], i == 9);
            check_model("basic");
        end
        chk("basic.valid", 32'(bus.o_valid), 1);
        chk("basic.bin5", obin(5), 4);
        chk("basic.bin200", obin(200), 5);
        chk("basic.bin0", obin(0), 1);
        chk("basic.sat", 32'(bus.o_frame_saturated), 0);
        idle();
        check_model("basic.drain");

        // Saturation: 65537 pixels of value 7
        bus.i_pixel_valid = 1'b1;
        bus.i_pixel       = 8'd7;
        bus.i_frame_end   = 1'b0;
        repeat (65536) step();
        beat(7, 1);
        chk("sat.valid", 32'(bus.o_valid), 1);
        chk("sat.bin7", obin(7), MAXB);
        chk("sat.flag", 32'(bus.o_frame_saturated), 1);
        check_model("sat");
        beat(7, 1);
        chk("sat_next.bin7", obin(7), 1);
        chk("sat_next.flag", 32'(bus.o_frame_saturated), 0);
        check_model("sat_next");
        idle();
        check_model("sat.drain");

        // Back-pressure
        bus.i_ready = 1'b0;
        beat(1, 1);
        check_model("bp.a");
        beat(2, 0);
        check_model("bp.b0");
        beat(2, 1);
        chk("bp.hold.pixel_ready", 32'(bus.o_pixel_ready), 0);
        chk("bp.hold.bin1", obin(1), 1);
        chk("bp.hold.valid", 32'(bus.o_valid), 1);
        check_model("bp.hold");
        beat(4, 1);
        chk("bp.hold2.bin1", obin(1), 1);
        check_model("bp.hold2");
        bus.i_ready = 1'b1;
        idle();
        chk("bp.release.bin2", obin(2), 2);
        chk("bp.release.valid", 32'(bus.o_valid), 1);
        chk("bp.release.pixel_ready", 32'(bus.o_pixel_ready), 1);
        check_model("bp.release");
        beat(3, 1);
        chk("bp.fresh.bin2", obin(2), 0);
        chk("bp.fresh.bin3", obin(3), 1);
        check_model("bp.fresh");
        idle();

        // Back-to-back single-beat frames
        for (int p = 1; p <= 3; p++) begin
            beat(p, 1);
            chk("b2b.valid", 32'(bus.o_valid), 1);
            chk("b2b.pixel_ready", 32'(bus.o_pixel_ready), 1);
            chk("b2b.bin", obin(p), 1);
            check_model("b2b");
        end
        idle();
        check_model("b2b.drain");

        // Reset mid-frame
        for (int i = 0; i < 3; i++) beat(9, 0);
        bus.i_pixel_valid = 1'b0;
        rst = 1'b1;
        step();
        check_model("midreset");
        rst = 1'b0;
        idle();
        beat(9, 1);
        chk("midreset.bin9", obin(9), 1);
        check_model("midreset.frame");
        idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.i_ready       = ($urandom_range(0, 2) != 0);
            bus.i_pixel_valid = ($urandom_range(0, 3) != 0);
            bus.i_pixel       = PW'($urandom_range(0, 15));
            bus.i_frame_end   = ($urandom_range(0, 4) == 0);
            step();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
